// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transaction front-end: address region layout,
// recovery counter width and the chip-select decoder FSM state encoding.
package hyperbus_pkg;

    typedef struct packed {
        logic [31:0] end_addr;
        logic [31:0] start_addr;
    } addr_region_t;

    localparam int RWR_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

endpackage

// File: rtl/hyperbus_addr_match.sv
// Combinational address decode: compares one address against every region and
// returns the lowest-index match together with the region-relative offset.
module hyperbus_addr_match
    import hyperbus_pkg::*;
#(
    parameter int NR_CS = 2,
    parameter int IDX_W = (NR_CS > 1) ? $clog2(NR_CS) : 1
) (
    input  logic [31:0]                  i_addr,
    input  addr_region_t [NR_CS-1:0]     i_regions,
    output logic                         o_hit,
    output logic [IDX_W-1:0]             o_idx,
    output logic [31:0]                  o_offset
);

    // Walking from the top index down lets the lowest matching index win.
    // A region with start > end can never satisfy both bounds, so it is disabled.
    always_comb begin
        o_hit    = 1'b0;
        o_idx    = '0;
        o_offset = '0;
        for (int i = NR_CS - 1; i >= 0; i--) begin
            if ((i_addr >= i_regions[i].start_addr) &&
                (i_addr <= i_regions[i].end_addr)) begin
                o_hit    = 1'b1;
                o_idx    = IDX_W'(i);
                o_offset = i_addr - i_regions[i].start_addr;
            end
        end
    end

endmodule

// File: rtl/hyperbus_cs_decoder.sv
// HyperBus transaction front-end: accepts one request, decodes it to a one-hot
// chip select and region-relative address, and enforces the t_RWR recovery gap.
module hyperbus_cs_decoder
    import hyperbus_pkg::*;
#(
    parameter int NR_CS              = 2,
    parameter int ADDR_MAPPING_WIDTH = 64 * NR_CS,
    parameter int BURST_W            = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [ADDR_MAPPING_WIDTH-1:0] cfg_addr_mapping_i,
    input  logic [31:0]                   cfg_t_rwr_i,
    input  logic                          trans_valid_i,
    output logic                          trans_ready_o,
    input  logic [31:0]                   trans_addr_i,
    input  logic                          trans_write_i,
    input  logic [BURST_W-1:0]            trans_burst_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NR_CS-1:0]              out_cs_o,
    output logic [31:0]                   out_addr_o,
    output logic                          out_write_o,
    output logic [BURST_W-1:0]            out_burst_o,
    output logic                          out_error_o,
    input  logic                          done_i,
    output logic                          busy_o
);

    localparam int IDX_W = (NR_CS > 1) ? $clog2(NR_CS) : 1;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [RWR_CNT_W-1:0]   r_cnt;
    logic [RWR_CNT_W-1:0]   w_cnt_nxt;
    logic                   w_accept;

    addr_region_t [NR_CS-1:0] w_regions;
    logic                     w_hit;
    logic [IDX_W-1:0]         w_idx;
    logic [31:0]              w_offset;
    logic [NR_CS-1:0]         w_cs_onehot;
    logic [RWR_CNT_W-1:0]     w_rwr;
    logic                     w_unused_rwr;

    logic [NR_CS-1:0]   r_cs_p1;
    logic [31:0]        r_addr_p1;
    logic               r_write_p1;
    logic [BURST_W-1:0] r_burst_p1;
    logic               r_error_p1;

    for (genvar g = 0; g < NR_CS; g++) begin : g_region
        assign w_regions[g].start_addr = cfg_addr_mapping_i[64*g      +: 32];
        assign w_regions[g].end_addr   = cfg_addr_mapping_i[64*g + 32 +: 32];
    end

    assign w_rwr        = cfg_t_rwr_i[RWR_CNT_W-1:0];
    assign w_unused_rwr = ^cfg_t_rwr_i[31:RWR_CNT_W];

    hyperbus_addr_match #(
        .NR_CS (NR_CS),
        .IDX_W (IDX_W)
    ) u_addr_match (
        .i_addr    (trans_addr_i),
        .i_regions (w_regions),
        .o_hit     (w_hit),
        .o_idx     (w_idx),
        .o_offset  (w_offset)
    );

    assign w_cs_onehot = w_hit ? (NR_CS'(1) << w_idx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (trans_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Error transactions never reach the memory, so no recovery gap.
                if (out_ready_i) begin
                    w_state_nxt = r_error_p1 ? ST_IDLE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (done_i) begin
                    w_cnt_nxt   = w_rwr;
                    w_state_nxt = (w_rwr == '0) ? ST_IDLE : ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (r_cnt <= RWR_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - RWR_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Accept stage: the map is only looked at here, so later map edits leave
    // the held transaction untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cs_p1    <= '0;
            r_addr_p1  <= '0;
            r_write_p1 <= 1'b0;
            r_burst_p1 <= '0;
            r_error_p1 <= 1'b0;
        end else if (w_accept) begin
            r_cs_p1    <= w_cs_onehot;
            r_addr_p1  <= w_hit ? w_offset : 32'd0;
            r_write_p1 <= trans_write_i;
            r_burst_p1 <= trans_burst_i;
            r_error_p1 <= ~w_hit;
        end
    end

    assign trans_ready_o = (r_state == ST_IDLE) && rst_ni;
    assign busy_o        = (r_state != ST_IDLE);
    assign out_valid_o   = (r_state == ST_ISSUE);
    assign out_cs_o      = r_cs_p1;
    assign out_addr_o    = r_addr_p1;
    assign out_write_o   = r_write_p1;
    assign out_burst_o   = r_burst_p1;
    assign out_error_o   = r_error_p1;

endmodule

// File: tb/tb_hyperbus_cs_decoder.sv
// Directed self-checking bench for hyperbus_cs_decoder with hand-computed expectations.
module tb_hyperbus_cs_decoder;

    localparam int NR_CS   = 2;
    localparam int MAP_W   = 64 * NR_CS;
    localparam int BURST_W = 16;

    localparam logic [MAP_W-1:0] DEFAULT_MAP =
        {32'h007F_FFFF, 32'h0040_0000, 32'h003F_FFFF, 32'h0000_0000};

    logic               clk;
    logic               rst_n;
    logic [MAP_W-1:0]   map;
    logic [31:0]        rwr;
    logic               tvalid;
    logic               tready;
    logic [31:0]        taddr;
    logic               twrite;
    logic [BURST_W-1:0] tburst;
    logic               ovalid;
    logic               oready;
    logic [NR_CS-1:0]   ocs;
    logic [31:0]        oaddr;
    logic               owrite;
    logic [BURST_W-1:0] oburst;
    logic               oerr;
    logic               done;
    logic               busy;

    int n_checks;
    int n_fail;

    hyperbus_cs_decoder #(
        .NR_CS              (NR_CS),
        .ADDR_MAPPING_WIDTH (MAP_W),
        .BURST_W            (BURST_W)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .cfg_addr_mapping_i (map),
        .cfg_t_rwr_i        (rwr),
        .trans_valid_i      (tvalid),
        .trans_ready_o      (tready),
        .trans_addr_i       (taddr),
        .trans_write_i      (twrite),
        .trans_burst_i      (tburst),
        .out_valid_o        (ovalid),
        .out_ready_i        (oready),
        .out_cs_o           (ocs),
        .out_addr_o         (oaddr),
        .out_write_o        (owrite),
        .out_burst_o        (oburst),
        .out_error_o        (oerr),
        .done_i             (done),
        .busy_o             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a, input logic w, input logic [BURST_W-1:0] b);
        tvalid = 1'b1;
        taddr  = a;
        twrite = w;
        tburst = b;
        tick();
        tvalid = 1'b0;
    endtask

    task automatic finish_txn();
        oready = 1'b1;
        tick();
        oready = 1'b0;
        rwr    = 32'd0;
        done   = 1'b1;
        tick();
        done   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b expected 0", tready); end
        n_checks++;
        if ({ovalid, ocs, oaddr, owrite, oburst, oerr, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b cs=%b a=%h w=%b b=%h e=%b busy=%b expected all 0",
                     ovalid, ocs, oaddr, owrite, oburst, oerr, busy);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", tready); end
        tick();
        n_checks++;
        if (busy !== 1'b0 || ovalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0/0", busy, ovalid);
        end
    endtask

    task automatic test_decode();
        send_req(32'h0040_1234, 1'b0, 16'h0010);
        n_checks++;
        if (ovalid !== 1'b1) begin n_fail++; $display("FAIL decode_valid: got %b expected 1", ovalid); end
        n_checks++;
        if (ocs !== 2'b10) begin n_fail++; $display("FAIL decode_cs: got %b expected 10", ocs); end
        n_checks++;
        if (oaddr !== 32'h0000_1234) begin n_fail++; $display("FAIL decode_addr: got %h expected 00001234", oaddr); end
        n_checks++;
        if (oerr !== 1'b0 || owrite !== 1'b0 || oburst !== 16'h0010) begin
            n_fail++; $display("FAIL decode_fields: got e=%b w=%b b=%h expected 0/0/0010", oerr, owrite, oburst);
        end
        n_checks++;
        if (tready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL decode_busy: got ready=%b busy=%b expected 0/1", tready, busy);
        end
        oready = 1'b1;
        tick();
        oready = 1'b0;
        n_checks++;
        if (ovalid !== 1'b0 || tready !== 1'b0) begin
            n_fail++; $display("FAIL decode_active: got valid=%b ready=%b expected 0/0", ovalid, tready);
        end
        rwr  = 32'd0;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (tready !== 1'b1) begin n_fail++; $display("FAIL decode_back_idle: got %b expected 1", tready); end
    endtask

    task automatic test_error();
        send_req(32'h0080_0000, 1'b1, 16'h0003);
        n_checks++;
        if (ovalid !== 1'b1 || ocs !== 2'b00 || oerr !== 1'b1 || oaddr !== 32'd0) begin
            n_fail++;
            $display("FAIL error_decode: got v=%b cs=%b e=%b a=%h expected 1/00/1/00000000", ovalid, ocs, oerr, oaddr);
        end
        oready = 1'b1;
        tick();
        oready = 1'b0;
        n_checks++;
        if (tready !== 1'b1 || busy !== 1'b0 || ovalid !== 1'b0) begin
            n_fail++; $display("FAIL error_no_recover: got ready=%b busy=%b valid=%b expected 1/0/0", tready, busy, ovalid);
        end
    endtask

    task automatic test_stall();
        send_req(32'h0000_0100, 1'b1, 16'hABCD);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) map = {32'h0000_00FF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0200};
            n_checks++;
            if (ovalid !== 1'b1 || ocs !== 2'b01 || oaddr !== 32'h100 || owrite !== 1'b1 ||
                oburst !== 16'hABCD || tready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b cs=%b a=%h w=%b b=%h r=%b expected 1/01/00000100/1/abcd/0",
                         k, ovalid, ocs, oaddr, owrite, oburst, tready);
            end
            tick();
        end
        map = DEFAULT_MAP;
        // done on the handshake cycle must not end the transaction
        rwr    = 32'd0;
        oready = 1'b1;
        done   = 1'b1;
        tick();
        oready = 1'b0;
        done   = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || tready !== 1'b0) begin
            n_fail++; $display("FAIL done_on_handshake: got busy=%b ready=%b expected 1/0", busy, tready);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (tready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_in_idle: got ready=%b busy=%b expected 1/0", tready, busy);
        end
    endtask

    task automatic test_recovery(input logic [31:0] cfg, input int n);
        send_req(32'h0000_2000, 1'b0, 16'h0001);
        oready = 1'b1;
        tick();
        oready = 1'b0;
        tick();
        rwr  = cfg;
        done = 1'b1;
        tick();
        done = 1'b0;
        rwr  = 32'h0000_000F;
        for (int k = 1; k <= n; k++) begin
            n_checks++;
            if (tready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL recover_cfg%0h_t+%0d: got ready=%b busy=%b expected 0/1", cfg, k, tready, busy);
            end
            tick();
        end
        n_checks++;
        if (tready !== 1'b1) begin
            n_fail++; $display("FAIL recover_cfg%0h_end_t+%0d: got ready=%b expected 1", cfg, n + 1, tready);
        end
    endtask

    task automatic test_overlap();
        map = {32'h007F_FFFF, 32'h0000_0000, 32'h003F_FFFF, 32'h0000_0000};
        send_req(32'h0000_0010, 1'b0, 16'h0002);
        n_checks++;
        if (ocs !== 2'b01 || oaddr !== 32'h10) begin
            n_fail++; $display("FAIL overlap_low_wins: got cs=%b a=%h expected 01/00000010", ocs, oaddr);
        end
        finish_txn();
        map = {32'h007F_FFFF, 32'h0000_0000, 32'h0000_0004, 32'h0000_0005};
        send_req(32'h0000_0010, 1'b0, 16'h0002);
        n_checks++;
        if (ocs !== 2'b10 || oaddr !== 32'h10 || oerr !== 1'b0) begin
            n_fail++; $display("FAIL disabled_region: got cs=%b a=%h e=%b expected 10/00000010/0", ocs, oaddr, oerr);
        end
        finish_txn();
        map = DEFAULT_MAP;
    endtask

    task automatic test_async_reset();
        send_req(32'h0040_0008, 1'b1, 16'h0055);
        oready = 1'b1;
        tick();
        oready = 1'b0;
        rwr  = 32'd6;
        done = 1'b1;
        tick();
        done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tready, busy, ovalid, ocs, oaddr, owrite, oburst, oerr} !== '0) begin
            n_fail++;
            $display("FAIL async_rst_recover: got r=%b busy=%b v=%b cs=%b a=%h w=%b b=%h e=%b expected all 0",
                     tready, busy, ovalid, ocs, oaddr, owrite, oburst, oerr);
        end
        tick();
        rst_n = 1'b1;
        send_req(32'h0040_0008, 1'b1, 16'h0055);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tready, busy, ovalid, ocs, oaddr, owrite, oburst, oerr} !== '0) begin
            n_fail++;
            $display("FAIL async_rst_issue: got r=%b busy=%b v=%b cs=%b a=%h w=%b b=%h e=%b expected all 0",
                     tready, busy, ovalid, ocs, oaddr, owrite, oburst, oerr);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tready !== 1'b1) begin n_fail++; $display("FAIL async_rst_release_ready: got %b expected 1", tready); end
        tick();
        send_req(32'h003F_FFFF, 1'b0, 16'h0007);
        n_checks++;
        if (ovalid !== 1'b1 || ocs !== 2'b01 || oaddr !== 32'h003F_FFFF || oerr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_redecode: got v=%b cs=%b a=%h e=%b expected 1/01/003fffff/0", ovalid, ocs, oaddr, oerr);
        end
        finish_txn();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        map      = DEFAULT_MAP;
        rwr      = 32'd6;
        tvalid   = 1'b0;
        taddr    = '0;
        twrite   = 1'b0;
        tburst   = '0;
        oready   = 1'b0;
        done     = 1'b0;
        #1;
        test_reset();
        test_decode();
        test_error();
        test_stall();
        test_recovery(32'd6, 6);
        test_recovery(32'd0, 0);
        test_recovery(32'h13, 3);
        test_overlap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_cs_decoder.md
Name: hyperbus_cs_decoder

Overview:
Transaction front-end stage sitting directly downstream of the HyperBus configuration register block and upstream of the HyperBus PHY/timing FSM. Accepts one memory transaction at a time over a valid/ready handshake. Decodes its address against the per-chip-select address map to produce a one-hot chip select and a region-relative address. Enforces the configured read-write recovery gap (t_RWR) between consecutive transactions issued to the PHY.

Parameters:
NR_CS, 2, number of chip selects / address regions
ADDR_MAPPING_WIDTH, 64*NR_CS, width of the packed address map; two 32-bit words per CS, start at [64i+31:64i], end at [64i+63:64i+32]
BURST_W, 16, width of the burst length field

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
cfg_addr_mapping_i  in  ADDR_MAPPING_WIDTH  address map from config registers
cfg_t_rwr_i  in  32  recovery cycles between transactions; only [3:0] used
trans_valid_i  in  1  upstream request valid
trans_ready_o  out  1  upstream request ready
trans_addr_i  in  32  absolute byte address
trans_write_i  in  1  1 = write, 0 = read
trans_burst_i  in  BURST_W  burst length, passed through unchanged
out_valid_o  out  1  decoded transaction valid to PHY
out_ready_i  in  1  PHY accepts transaction
out_cs_o  out  NR_CS  one-hot chip select; all-zero on decode error
out_addr_o  out  32  trans_addr_i minus start of matched region (mod 2^32); 0 on error
out_write_o  out  1  registered trans_write_i
out_burst_o  out  BURST_W  registered trans_burst_i
out_error_o  out  1  address matched no region
done_i  in  1  single-cycle pulse from PHY: issued transaction finished, CS deasserted
busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset: state IDLE; out_valid_o, out_cs_o, out_addr_o, out_write_o, out_burst_o, out_error_o = 0; busy_o = 0; recovery counter = 0; trans_ready_o = 1 after reset release.
- FSM states: IDLE, ISSUE, ACTIVE, RECOVER.
- IDLE: trans_ready_o = 1. On trans_valid_i: decode, register all out_* fields, go to ISSUE. out_valid_o rises the next cycle (1-cycle latency).
- Decode: region i matches iff start_i <= addr <= end_i (unsigned, inclusive). A region with start_i > end_i is disabled. On overlap, the lowest index wins. No match: out_cs_o = 0, out_error_o = 1.
- The address map is sampled only in the accept cycle. Map changes while busy do not affect the held transaction.
- ISSUE: out_valid_o = 1 and all out_* stable until out_ready_i. On handshake, error transaction -> IDLE (no recovery); otherwise -> ACTIVE. out_valid_o drops the cycle after the handshake.
- ACTIVE: trans_ready_o = 0. On done_i, load counter with cfg_t_rwr_i[3:0], sampled at that cycle. Value 0 -> IDLE directly; else -> RECOVER.
- RECOVER: decrement each cycle; -> IDLE when counter reaches 1. IDLE is entered exactly N cycles after the done_i cycle, so there are N non-ready cycles after done_i.
- done_i outside ACTIVE is ignored. done_i in the same cycle as the ISSUE handshake is ignored.
- trans_ready_o = 0 in ISSUE, ACTIVE and RECOVER. At most one transaction is outstanding.
- Reset asserted in any state returns all outputs to reset values immediately; the held transaction is dropped.

Decomposition:
- Shared hyperbus package: typedef addr_region_t {start, end : logic[31:0]}; constant RWR_CNT_W = 4; typedef state enum for the FSM.
- Sub-module hyperbus_addr_match: combinational per-region compare plus priority select (region index, hit, offset). Instantiated once, with NR_CS region inputs.

Test Plan:
- Default map (0..3FFFFF, 400000..7FFFFF), rwr=6; request addr 0x00401234 read -> next cycle out_valid_o=1, out_cs_o=2'b10, out_addr_o=0x1234, out_error_o=0.
- Addr 0x00800000 -> out_cs_o=0, out_error_o=1; after handshake trans_ready_o=1 the following cycle, no recovery.
- Valid addr, out_ready_i held low 5 cycles -> out_* stable for all 5 cycles; trans_ready_o=0 throughout.
- rwr=6, done_i pulse at cycle t -> trans_ready_o=0 for cycles t+1..t+6, 1 at t+7; with rwr=0 -> 1 at t+1; with cfg_t_rwr_i=0x13 -> counts 3.
- Map region1 = 0..7FFFFF overlapping region0; addr 0x10 -> out_cs_o=2'b01. Region0 start=5 > end=4 -> addr 0x10 gives out_cs_o=2'b10.
- rst_ni low during RECOVER and during ISSUE -> all outputs 0 asynchronously; after release, a new request decodes normally.
